// File: rtl/ov5640_pkg.sv
// ov5640_pkg: shared definitions for the OV5640 DVP capture front end.
//   - cap_state_t     : capture state machine encoding (SETTLE, IDLE, CAPTURE)
//   - CAPTURE_LATENCY : clocks from second pixel byte on cam_data to cmos_* output
//   - RGB_*           : RGB565 colour-bar constants, with a lookup helper
package ov5640_pkg;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    IDLE    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  localparam int CAPTURE_LATENCY = 2;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  // Bar index 0..7 runs left to right: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [15:0] colour_bar(input logic [2:0] idx);
    case (idx)
      3'd0:    colour_bar = RGB_WHITE;
      3'd1:    colour_bar = RGB_YELLOW;
      3'd2:    colour_bar = RGB_CYAN;
      3'd3:    colour_bar = RGB_GREEN;
      3'd4:    colour_bar = RGB_MAGENTA;
      3'd5:    colour_bar = RGB_RED;
      3'd6:    colour_bar = RGB_BLUE;
      default: colour_bar = RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ov5640_byte_packer.sv
// ov5640_byte_packer: pairs consecutive DVP bytes of a line into RGB565 words.
// Ports:
//   clk, rst      : pixel clock, asynchronous active-high reset
//   href, data    : stage-0 registered line-valid and pixel byte
//   gate          : high while bytes belong to a captured frame (outside blanking)
//   pat_sel       : substitute pat_word for the sensor word on each strobe
//   pat_word      : replacement word (test pattern)
//   pix_word      : packed word, first byte in [15:8]; holds between strobes
//   pix_valid     : one-cycle strobe per packed word
//   odd_line_err  : sticky, a gated line ended on a dangling first byte
module ov5640_byte_packer
  import ov5640_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        href,
  input  logic [7:0]  data,
  input  logic        gate,
  input  logic        pat_sel,
  input  logic [15:0] pat_word,
  output logic [15:0] pix_word,
  output logic        pix_valid,
  output logic        odd_line_err
);

  logic       phase_r;
  logic       href_d_r;
  logic [7:0] hi_r;

  // Byte-phase tracking, pair assembly and odd-line detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_r      <= 1'b0;
      href_d_r     <= 1'b0;
      hi_r         <= 8'h00;
      pix_word     <= 16'h0000;
      pix_valid    <= 1'b0;
      odd_line_err <= 1'b0;
    end else begin
      href_d_r  <= href;
      pix_valid <= 1'b0;
      // A line that ends while a first byte is waiting: flag it, the byte is dropped.
      if (href_d_r && !href && phase_r) begin
        odd_line_err <= 1'b1;
      end
      if (!href) begin
        phase_r <= 1'b0;
      end else if (gate) begin
        if (!phase_r) begin
          hi_r    <= data;
          phase_r <= 1'b1;
        end else begin
          pix_word  <= pat_sel ? pat_word : {hi_r, data};
          pix_valid <= 1'b1;
          phase_r   <= 1'b0;
        end
      end else begin
        phase_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ov5640_dvp_capture.sv
// ov5640_dvp_capture: OV5640 DVP capture front end (single pixel-clock domain).
// Skips SKIP_FRAMES sensor-settling frames after reset, then captures whole
// frames while capture_en is high, packing byte pairs into RGB565 words.
// Optional build macro: OV5640_CAPTURE_TESTPAT_EN adds input testpat_sel, which
// replaces captured pixel data with 8 vertical colour bars.
// Ports:
//   clk, rst          : pixel clock (cam_pclk), asynchronous active-high reset
//   capture_en        : capture request, honoured only at frame boundaries
//   cam_vsync/href/data : raw sensor DVP bus
//   cmos_frame_vsync  : active-high vsync, 2 clk delayed, 0 while settling
//   cmos_frame_href   : href of captured frames, 2 clk delayed
//   cmos_frame_valid  : one-cycle strobe per packed pixel
//   cmos_wr_data      : packed RGB565 pixel, first byte in [15:8]
//   frame_cnt         : count of completed captured frames (wraps)
//   odd_line_err      : sticky odd-byte-count line flag
module ov5640_dvp_capture
  import ov5640_pkg::*;
#(
  parameter int SKIP_FRAMES       = 10,
  parameter int VSYNC_ACTIVE_HIGH = 1,
  parameter int FRAME_CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef OV5640_CAPTURE_TESTPAT_EN
  input  logic                   testpat_sel,
`endif
  input  logic                   capture_en,
  input  logic                   cam_vsync,
  input  logic                   cam_href,
  input  logic [7:0]             cam_data,
  output logic                   cmos_frame_vsync,
  output logic                   cmos_frame_href,
  output logic                   cmos_frame_valid,
  output logic [15:0]            cmos_wr_data,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   odd_line_err
);

  localparam int SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic VS_INVERT = (VSYNC_ACTIVE_HIGH == 0);

  logic                   vsync_r;
  logic                   href_r;
  logic [7:0]             data_r;
  logic                   vs_n_d_r;
  logic                   vs_n_s;
  logic                   vs_rise_s;
  logic                   vs_fall_s;
  logic                   gate_s;
  cap_state_t             state_r;
  logic [SKIP_W-1:0]      skip_cnt_r;
  logic [FRAME_CNT_W-1:0] frame_cnt_r;
  logic                   frame_vsync_r;
  logic                   frame_href_r;
  logic                   pat_sel_s;
  logic [15:0]            pat_word_s;

  // Stage 0: register the sensor bus once; vsync resets to its inactive level
  // so leaving reset never looks like a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_r  <= VS_INVERT;
      href_r   <= 1'b0;
      data_r   <= 8'h00;
      vs_n_d_r <= 1'b0;
    end else begin
      vsync_r  <= cam_vsync;
      href_r   <= cam_href;
      data_r   <= cam_data;
      vs_n_d_r <= vs_n_s;
    end
  end

  assign vs_n_s    = vsync_r ^ VS_INVERT;
  assign vs_rise_s = vs_n_s & ~vs_n_d_r;
  assign vs_fall_s = ~vs_n_s & vs_n_d_r;
  // href during vsync-active is blanking, never pixel data.
  assign gate_s    = (state_r == CAPTURE) && !vs_n_s;

  // Frame-boundary state machine, frame counter and delayed sync outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= SETTLE;
      skip_cnt_r    <= {SKIP_W{1'b0}};
      frame_cnt_r   <= {FRAME_CNT_W{1'b0}};
      frame_vsync_r <= 1'b0;
      frame_href_r  <= 1'b0;
    end else begin
      frame_vsync_r <= (state_r != SETTLE) ? vs_n_s : 1'b0;
      frame_href_r  <= gate_s & href_r;
      case (state_r)
        SETTLE: begin
          if (skip_cnt_r == SKIP_W'(SKIP_FRAMES)) begin
            state_r <= IDLE;
          end else if (vs_rise_s) begin
            skip_cnt_r <= skip_cnt_r + SKIP_W'(1);
          end
        end
        IDLE: begin
          if (vs_fall_s && capture_en) begin
            state_r <= CAPTURE;
          end
        end
        CAPTURE: begin
          // vs_rise closes a captured frame; capture_en decides whether the next one follows.
          if (vs_rise_s) begin
            frame_cnt_r <= frame_cnt_r + FRAME_CNT_W'(1);
            if (!capture_en) begin
              state_r <= IDLE;
            end
          end
        end
        default: state_r <= SETTLE;
      endcase
    end
  end

`ifdef OV5640_CAPTURE_TESTPAT_EN
  logic [10:0] pix_cnt_r;
  logic        tp_href_d_r;

  // Pixel-in-line counter for the colour bars: cleared at href rise, advanced per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt_r   <= 11'd0;
      tp_href_d_r <= 1'b0;
    end else begin
      tp_href_d_r <= href_r;
      if (href_r && !tp_href_d_r) begin
        pix_cnt_r <= 11'd0;
      end else if (cmos_frame_valid) begin
        pix_cnt_r <= pix_cnt_r + 11'd1;
      end
    end
  end

  assign pat_sel_s  = testpat_sel;
  assign pat_word_s = colour_bar(pix_cnt_r[9:7]);
`else
  assign pat_sel_s  = 1'b0;
  assign pat_word_s = 16'h0000;
`endif

  ov5640_byte_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .href         (href_r),
    .data         (data_r),
    .gate         (gate_s),
    .pat_sel      (pat_sel_s),
    .pat_word     (pat_word_s),
    .pix_word     (cmos_wr_data),
    .pix_valid    (cmos_frame_valid),
    .odd_line_err (odd_line_err)
  );

  assign cmos_frame_vsync = frame_vsync_r;
  assign cmos_frame_href  = frame_href_r;
  assign frame_cnt        = frame_cnt_r;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Testbench for ov5640_dvp_capture: scoreboard of expected RGB565 words with
// arrival-cycle checks, plus a second instance with inverted sensor vsync that
// must reproduce the active-high instance's outputs cycle for cycle.
module tb_ov5640_dvp_capture;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [15:0] d;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_vsync_inv;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;

  logic        a_vs, a_href, a_valid, a_odd;
  logic [15:0] a_data;
  logic [7:0]  a_fcnt;
  logic        b_vs, b_href, b_valid, b_odd;
  logic [15:0] b_data;
  logic [7:0]  b_fcnt;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  bit   href_seen = 1'b0;
  int   exp_fcnt = 0;
  exp_t sb[$];
  exp_t mon_e;

  assign cam_vsync_inv = ~cam_vsync;

  ov5640_dvp_capture #(.SKIP_FRAMES(2), .VSYNC_ACTIVE_HIGH(1), .FRAME_CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .capture_en(capture_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .cmos_frame_vsync(a_vs),
    .cmos_frame_href(a_href), .cmos_frame_valid(a_valid), .cmos_wr_data(a_data),
    .frame_cnt(a_fcnt), .odd_line_err(a_odd)
  );

  ov5640_dvp_capture #(.SKIP_FRAMES(2), .VSYNC_ACTIVE_HIGH(0), .FRAME_CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .capture_en(capture_en), .cam_vsync(cam_vsync_inv),
    .cam_href(cam_href), .cam_data(cam_data), .cmos_frame_vsync(b_vs),
    .cmos_frame_href(b_href), .cmos_frame_valid(b_valid), .cmos_wr_data(b_data),
    .frame_cnt(b_fcnt), .odd_line_err(b_odd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every strobe and compares both polarities.
  always @(negedge clk) begin
    if (a_valid) begin
      valid_cnt = valid_cnt + 1;
      checks = checks + 1;
      if (sb.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_valid: got data %h at cycle %0d, no pixel expected", a_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (a_data !== mon_e.d) begin
          failures = failures + 1;
          $display("FAIL pixel_data: got %h, expected %h", a_data, mon_e.d);
        end
        checks = checks + 1;
        if (cyc !== mon_e.t) begin
          failures = failures + 1;
          $display("FAIL pixel_latency: strobe at cycle %0d, expected cycle %0d", cyc, mon_e.t);
        end
      end
    end
    if (a_href) href_seen = 1'b1;
    checks = checks + 1;
    if ({a_vs, a_href, a_valid, a_data, a_fcnt, a_odd} !== {b_vs, b_href, b_valid, b_data, b_fcnt, b_odd}) begin
      failures = failures + 1;
      $display("FAIL polarity_match: active-high %b/%b/%b/%h/%0d/%b, inverted %b/%b/%b/%h/%0d/%b",
               a_vs, a_href, a_valid, a_data, a_fcnt, a_odd, b_vs, b_href, b_valid, b_data, b_fcnt, b_odd);
    end
  end

  function automatic byte_q_t make_line(input logic [7:0] base, input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(base + 8'(i * 37));
    return q;
  endfunction

  task automatic send_line(input byte_q_t bq, input bit cap);
    exp_t e;
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = bq[i];
      if (cap && (i % 2 == 1)) begin
        e.d = {bq[i-1], bq[i]};
        e.t = cyc + 2;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input int lines, input int nbytes, input bit cap, input logic [7:0] base);
    for (int l = 0; l < lines; l++) send_line(make_line(base + 8'(l * 16), nbytes), cap);
  endtask

  // Blanking pulse; checks output vsync level and frame counter mid-pulse.
  task automatic vsync_pulse(input bit counted, input bit raise_en, input logic exp_vs);
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if (a_vs !== exp_vs) begin
      failures = failures + 1;
      $display("FAIL frame_vsync: got %b, expected %b", a_vs, exp_vs);
    end
    if (counted) exp_fcnt = exp_fcnt + 1;
    checks = checks + 1;
    if (a_fcnt !== 8'(exp_fcnt)) begin
      failures = failures + 1;
      $display("FAIL frame_cnt: got %0d, expected %0d", a_fcnt, exp_fcnt);
    end
    if (raise_en) capture_en = 1'b1;
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame_valids(input string name, input int expv);
    checks = checks + 1;
    if (valid_cnt !== expv) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d strobes, expected %0d", name, valid_cnt, expv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    capture_en = 1'b1;
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if ({a_vs, a_href, a_valid, a_data, a_fcnt, a_odd} !== 28'd0) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got %h, expected 0", {a_vs, a_href, a_valid, a_data, a_fcnt, a_odd});
    end
    rst = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if ({a_vs, a_href, a_valid, a_data, a_fcnt, a_odd} !== 28'd0) begin
      failures = failures + 1;
      $display("FAIL post_reset_outputs: got %h, expected 0", {a_vs, a_href, a_valid, a_data, a_fcnt, a_odd});
    end
  endtask

  task automatic test_skip_frames();
    valid_cnt = 0; send_frame(4, 8, 1'b0, 8'h10); check_frame_valids("skip_frame1", 0);
    vsync_pulse(1'b0, 1'b0, 1'b0);
    valid_cnt = 0; send_frame(4, 8, 1'b0, 8'h20); check_frame_valids("skip_frame2", 0);
    vsync_pulse(1'b0, 1'b0, 1'b0);
    valid_cnt = 0; send_frame(4, 8, 1'b1, 8'h30); check_frame_valids("capture_frame3", 16);
    vsync_pulse(1'b1, 1'b0, 1'b1);
    valid_cnt = 0; send_frame(4, 8, 1'b1, 8'h40); check_frame_valids("capture_frame4", 16);
    vsync_pulse(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_pack_order();
    byte_q_t bq;
    bq = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    valid_cnt = 0;
    send_line(bq, 1'b1);
    check_frame_valids("pack_line", 2);
    repeat (3) @(negedge clk);
    checks = checks + 1;
    if (a_data !== 16'hABCD) begin
      failures = failures + 1;
      $display("FAIL data_hold: got %h, expected abcd", a_data);
    end
    vsync_pulse(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_odd_line();
    checks = checks + 1;
    if (a_odd !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL odd_before: got %b, expected 0", a_odd);
    end
    valid_cnt = 0;
    send_line(make_line(8'h50, 7), 1'b1);
    check_frame_valids("odd_line_valids", 3);
    checks = checks + 1;
    if (a_odd !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL odd_set: got %b, expected 1", a_odd);
    end
    send_frame(2, 8, 1'b1, 8'h60);
    checks = checks + 1;
    if (a_odd !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL odd_sticky: got %b, expected 1", a_odd);
    end
    vsync_pulse(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_capture_toggle();
    valid_cnt = 0;
    send_frame(2, 8, 1'b1, 8'h70);
    capture_en = 1'b0;
    send_frame(2, 8, 1'b1, 8'h90);
    check_frame_valids("dropped_frame_completes", 16);
    vsync_pulse(1'b1, 1'b0, 1'b1);
    valid_cnt = 0;
    href_seen = 1'b0;
    send_frame(4, 8, 1'b0, 8'hA0);
    check_frame_valids("idle_frame", 0);
    checks = checks + 1;
    if (href_seen !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL idle_href: got href high, expected low");
    end
    vsync_pulse(1'b0, 1'b1, 1'b1);
    valid_cnt = 0;
    send_frame(4, 8, 1'b1, 8'hB0);
    check_frame_valids("resumed_frame", 16);
    vsync_pulse(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    byte_q_t bq;
    exp_t e;
    bq = make_line(8'hC0, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cam_href = 1'b1;
      cam_data = bq[i];
      if (i % 2 == 1) begin
        e.d = {bq[i-1], bq[i]};
        e.t = cyc + 2;
        sb.push_back(e);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks = checks + 1;
    if ({a_vs, a_href, a_valid, a_data, a_fcnt, a_odd} !== 28'd0) begin
      failures = failures + 1;
      $display("FAIL mid_reset_outputs: got %h, expected 0", {a_vs, a_href, a_valid, a_data, a_fcnt, a_odd});
    end
    sb.delete();
    @(negedge clk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    exp_fcnt = 0;
    valid_cnt = 0;
    vsync_pulse(1'b0, 1'b0, 1'b0);
    send_frame(2, 8, 1'b0, 8'hD0);
    vsync_pulse(1'b0, 1'b0, 1'b0);
    check_frame_valids("resettle_frames", 0);
    valid_cnt = 0;
    send_frame(4, 8, 1'b1, 8'hE0);
    check_frame_valids("post_resettle_capture", 16);
    vsync_pulse(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_skip_frames();
    test_pack_order();
    test_odd_line();
    test_capture_toggle();
    test_reset_mid();
    repeat (4) @(negedge clk);
    checks = checks + 1;
    if (sb.size() !== 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: %0d pixels never emitted, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
